// File: rtl/axi_write_stager_pkg.sv
// Shared types and constants for the AXI write stager.
package axi_write_stager_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FILL      = 3'd1,
    S_REQ       = 3'd2,
    S_DATA      = 3'd3,
    S_WAIT_DONE = 3'd4,
    S_FINISH    = 3'd5
  } state_e;

  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned DEF_BURST_LEN  = 16;

endpackage

// File: rtl/axi_write_stager_stage_fifo.sv
// Synchronous staging FIFO with a registered head word.
// Simultaneous push and pop is accepted even when full.
module axi_write_stager_stage_fifo #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [DATA_W-1:0]        din,
  output logic [DATA_W-1:0]        dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [DATA_W-1:0] head_q, head_d;
  logic              do_push, do_pop;

  assign do_pop  = pop && (count_q != '0);
  assign do_push = push && ((count_q != CW'(DEPTH)) || do_pop);

  // Head follows the new read pointer; a push into an emptying FIFO bypasses to the head.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    head_d   = head_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    if (do_push && ((count_q == '0) || (do_pop && (count_q == CW'(1))))) begin
      head_d = din;
    end else if (do_pop && (count_q > CW'(1))) begin
      head_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      head_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      head_q   <= head_d;
    end
  end

  assign dout  = head_q;
  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;

endmodule

// File: rtl/axi_write_stager.sv
// Buffers a result stream and hands it to the AXI write stage as
// address-advancing bursts of up to BURST_LEN beats.
module axi_write_stager
  import axi_write_stager_pkg::*;
#(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned BURST_LEN  = DEF_BURST_LEN,
  parameter int unsigned FIFO_DEPTH = 32,
  parameter int unsigned CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_base_addr,
  input  logic [CNT_W-1:0]  cfg_total_words,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [ADDR_W-1:0] write_addr_out,
  output logic [DATA_W-1:0] write_data_out,
  output logic [31:0]       write_data_len_out,
  output logic              write_en_out,
  input  logic              write_beat_in,
  input  logic              write_done_in,
  output logic              busy,
  output logic              done,
  output logic              err_align
);

  localparam int unsigned LEN_W = $clog2(BURST_LEN) + 1;
  localparam int unsigned FCW   = $clog2(FIFO_DEPTH) + 1;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  total_q, total_d;
  logic [CNT_W-1:0]  remaining_q, remaining_d;
  logic [CNT_W-1:0]  accepted_q, accepted_d;
  logic [LEN_W-1:0]  burst_len_q, burst_len_d;
  logic [LEN_W-1:0]  beats_left_q, beats_left_d;
  logic [ADDR_W-1:0] write_addr_q, write_addr_d;
  logic [LEN_W-1:0]  write_len_q, write_len_d;
  logic              write_en_q, write_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_align_q, err_align_d;

  logic              push, pop;
  logic              fifo_full, fifo_empty;
  logic [FCW-1:0]    fifo_count;
  logic [LEN_W-1:0]  burst_len_c;
  logic              fill_ready, last_beat, burst_final, burst_done;
  logic              start_ok, aligned;

  axi_write_stager_stage_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_stage_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (s_data),
    .dout  (write_data_out),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign s_ready     = busy_q && !fifo_full && (accepted_q < total_q);
  assign push        = s_valid && s_ready;
  assign pop         = (state_q == S_DATA) && write_beat_in && !fifo_empty;
  assign burst_len_c = (remaining_q < CNT_W'(BURST_LEN)) ? LEN_W'(remaining_q) : LEN_W'(BURST_LEN);
  assign fill_ready  = 32'(fifo_count) >= 32'(burst_len_c);
  assign last_beat   = pop && (beats_left_q == LEN_W'(1));
  assign burst_final = (remaining_q == CNT_W'(burst_len_q));
  // A done coincident with the last beat closes the burst in the same cycle.
  assign burst_done  = ((state_q == S_DATA) && last_beat && write_done_in) ||
                       ((state_q == S_WAIT_DONE) && write_done_in);
  assign start_ok    = (state_q == S_IDLE) && cfg_start;
  assign aligned     = (cfg_base_addr[1:0] == 2'b00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:      if (start_ok && aligned && (cfg_total_words != '0)) state_d = S_FILL;
      S_FILL:      if (fill_ready) state_d = S_REQ;
      S_REQ:       state_d = S_DATA;
      S_DATA:      if (last_beat) begin
                     if (write_done_in) state_d = burst_final ? S_FINISH : S_FILL;
                     else               state_d = S_WAIT_DONE;
                   end
      S_WAIT_DONE: if (write_done_in) state_d = burst_final ? S_FINISH : S_FILL;
      S_FINISH:    state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_comb begin
    addr_d       = addr_q;
    total_d      = total_q;
    remaining_d  = remaining_q;
    accepted_d   = accepted_q;
    burst_len_d  = burst_len_q;
    beats_left_d = beats_left_q;
    write_addr_d = write_addr_q;
    write_len_d  = write_len_q;
    err_align_d  = err_align_q;
    write_en_d   = (state_q == S_REQ);
    done_d       = (state_d == S_FINISH);
    busy_d       = (state_d == S_FILL) || (state_d == S_REQ) ||
                   (state_d == S_DATA) || (state_d == S_WAIT_DONE);

    if (start_ok) begin
      err_align_d = !aligned;
      if (aligned) begin
        addr_d      = cfg_base_addr;
        total_d     = cfg_total_words;
        remaining_d = cfg_total_words;
        accepted_d  = '0;
        if (cfg_total_words == '0) done_d = 1'b1;
      end
    end

    if (state_q == S_FILL) burst_len_d = burst_len_c;

    if (state_q == S_REQ) begin
      write_addr_d = addr_q;
      write_len_d  = burst_len_q;
      beats_left_d = burst_len_q;
    end

    if (pop) beats_left_d = beats_left_q - LEN_W'(1);

    if (burst_done) begin
      addr_d      = addr_q + ADDR_W'(burst_len_q) * ADDR_W'(BYTES_PER_WORD);
      remaining_d = remaining_q - CNT_W'(burst_len_q);
    end

    if (push) accepted_d = accepted_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q       <= '0;
      total_q      <= '0;
      remaining_q  <= '0;
      accepted_q   <= '0;
      burst_len_q  <= '0;
      beats_left_q <= '0;
      write_addr_q <= '0;
      write_len_q  <= '0;
      write_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_align_q  <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      total_q      <= total_d;
      remaining_q  <= remaining_d;
      accepted_q   <= accepted_d;
      burst_len_q  <= burst_len_d;
      beats_left_q <= beats_left_d;
      write_addr_q <= write_addr_d;
      write_len_q  <= write_len_d;
      write_en_q   <= write_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_align_q  <= err_align_d;
    end
  end

  assign write_addr_out     = write_addr_q;
  assign write_data_len_out = 32'(write_len_q);
  assign write_en_out       = write_en_q;
  assign busy               = busy_q;
  assign done               = done_q;
  assign err_align          = err_align_q;

endmodule

// File: tb/tb_axi_write_stager.sv
// Randomized bench for axi_write_stager with a behavioural write-stage model
// and burst/data scoreboard.
module tb_axi_write_stager;

  logic        clk = 1'b0;
  logic        rst;
  logic        cfg_start;
  logic [31:0] cfg_base_addr;
  logic [31:0] cfg_total_words;
  logic [31:0] s_data;
  logic        s_valid;
  logic        s_ready;
  logic [31:0] write_addr_out;
  logic [31:0] write_data_out;
  logic [31:0] write_data_len_out;
  logic        write_en_out;
  logic        write_beat_in;
  logic        write_done_in;
  logic        busy;
  logic        done;
  logic        err_align;

  axi_write_stager dut (
    .clk                (clk),
    .rst                (rst),
    .cfg_start          (cfg_start),
    .cfg_base_addr      (cfg_base_addr),
    .cfg_total_words    (cfg_total_words),
    .s_data             (s_data),
    .s_valid            (s_valid),
    .s_ready            (s_ready),
    .write_addr_out     (write_addr_out),
    .write_data_out     (write_data_out),
    .write_data_len_out (write_data_len_out),
    .write_en_out       (write_en_out),
    .write_beat_in      (write_beat_in),
    .write_done_in      (write_done_in),
    .busy               (busy),
    .done               (done),
    .err_align          (err_align)
  );

  always #5 clk = ~clk;

  int unsigned n_total = 0;
  int unsigned n_bad   = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference job description and stimulus words
  logic [31:0] data_mem [128];
  logic [31:0] exp_addr [$];
  int          exp_len  [$];
  bit          sink_fin  = 1'b0;
  int unsigned exp_total = 0;
  int unsigned acc_base  = 0;

  // Passive observers sampled on the falling edge
  int unsigned en_cnt = 0, done_cnt = 0, busy_cnt = 0, acc_cnt = 0;
  int unsigned over_cnt = 0, occ = 0, max_occ = 0;

  always @(negedge clk) begin
    if (write_en_out) en_cnt++;
    if (done) done_cnt++;
    if (busy) busy_cnt++;
    if (s_valid && s_ready) begin
      if (acc_cnt - acc_base >= exp_total) over_cnt++;
      acc_cnt++;
      occ++;
    end
    if (write_beat_in && occ != 0) occ--;
    if (occ > max_occ) max_occ = occ;
    if (rst) occ = 0;
  end

  task automatic source(input int unsigned vprob);
    int unsigned k = 0;
    int unsigned cyc = 0;
    while (!sink_fin && cyc < 5000) begin
      @(posedge clk); #1;
      s_valid = ($urandom_range(99) < vprob);
      s_data  = data_mem[k];
      @(negedge clk);
      if (s_valid && s_ready && k < 127) k++;
      cyc++;
    end
    @(posedge clk); #1;
    s_valid = 1'b0;
  endtask

  task automatic sink(input int smode, input bit coinc);
    int idx = 0;
    int cyc;
    int stall;
    int d;
    for (int b = 0; b < exp_addr.size(); b++) begin
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
      end while (!write_en_out && cyc < 1000);
      if (!write_en_out) begin
        chk("write_en_timeout", 64'd0, 64'd1);
        break;
      end
      chk("burst_addr", 64'(write_addr_out), 64'(exp_addr[b]));
      chk("burst_len", 64'(write_data_len_out), 64'(exp_len[b]));
      for (int i = 0; i < exp_len[b]; i++) begin
        if (smode == 1 && i == 7) stall = 5;
        else if (smode == 2)      stall = int'($urandom_range(1));
        else                      stall = 0;
        repeat (stall) begin
          @(posedge clk); #1;
          write_beat_in = 1'b0;
          write_done_in = 1'b0;
        end
        @(posedge clk); #1;
        write_beat_in = 1'b1;
        write_done_in = coinc && (i == exp_len[b] - 1);
        @(negedge clk);
        chk("beat_data", 64'(write_data_out), 64'(data_mem[idx]));
        idx++;
      end
      if (!coinc) begin
        d = int'($urandom_range(2));
        repeat (d) begin
          @(posedge clk); #1;
          write_beat_in = 1'b0;
          write_done_in = 1'b0;
        end
        @(posedge clk); #1;
        write_beat_in = 1'b0;
        write_done_in = 1'b1;
      end
      @(posedge clk); #1;
      write_beat_in = 1'b0;
      write_done_in = 1'b0;
    end
    sink_fin = 1'b1;
  endtask

  task automatic plan_job(input logic [31:0] base, input int unsigned total);
    logic [31:0] a = base;
    int unsigned rem = total;
    int unsigned l;
    exp_addr.delete();
    exp_len.delete();
    while (rem > 0) begin
      l = (rem < 16) ? rem : 16;
      exp_addr.push_back(a);
      exp_len.push_back(int'(l));
      a   = a + 32'(l * 4);
      rem = rem - l;
    end
    for (int i = 0; i < 128; i++) data_mem[i] = $urandom;
    acc_base  = acc_cnt;
    exp_total = total;
    sink_fin  = 1'b0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input int unsigned total);
    @(posedge clk); #1;
    cfg_start       = 1'b1;
    cfg_base_addr   = base;
    cfg_total_words = total;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic run_job(input logic [31:0] base, input int unsigned total,
                         input int unsigned vprob, input int smode, input bit coinc);
    int unsigned en0, dn0, ov0;
    plan_job(base, total);
    en0 = en_cnt;
    dn0 = done_cnt;
    ov0 = over_cnt;
    pulse_start(base, total);
    fork
      source(vprob);
      sink(smode, coinc);
    join
    repeat (4) @(negedge clk);
    chk("burst_count", 64'(en_cnt - en0), 64'(exp_addr.size()));
    chk("done_count", 64'(done_cnt - dn0), 64'd1);
    chk("accepted_words", 64'(acc_cnt - acc_base), 64'(total));
    chk("over_accept", 64'(over_cnt - ov0), 64'd0);
    chk("busy_after", 64'(busy), 64'd0);
    chk("err_align_after", 64'(err_align), 64'd0);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_write_en"}, 64'(write_en_out), 64'd0);
    chk({tag, "_write_addr"}, 64'(write_addr_out), 64'd0);
    chk({tag, "_write_data"}, 64'(write_data_out), 64'd0);
    chk({tag, "_write_len"}, 64'(write_data_len_out), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_done"}, 64'(done), 64'd0);
    chk({tag, "_err_align"}, 64'(err_align), 64'd0);
    chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
  endtask

  initial begin
    int unsigned en0, dn0, bz0, cyc;
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_base_addr = '0;
    cfg_total_words = '0;
    s_data = '0;
    s_valid = 1'b0;
    write_beat_in = 1'b0;
    write_done_in = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    rst = 1'b0;
    repeat (2) @(posedge clk);

    // Two full bursts, stream and beats back-to-back
    run_job(32'h0000_1000, 32, 100, 0, 1'b0);
    // Full burst plus partial tail; 21st word must be refused
    run_job(32'h0000_2000, 20, 100, 0, 1'b0);

    // Misaligned start is rejected and flagged
    en0 = en_cnt; dn0 = done_cnt; bz0 = busy_cnt;
    pulse_start(32'h0000_3002, 5);
    repeat (10) @(negedge clk);
    chk("misalign_err", 64'(err_align), 64'd1);
    chk("misalign_no_en", 64'(en_cnt - en0), 64'd0);
    chk("misalign_no_done", 64'(done_cnt - dn0), 64'd0);
    chk("misalign_no_busy", 64'(busy_cnt - bz0), 64'd0);
    run_job(32'h0000_3000, 1, 100, 0, 1'b0);

    // Zero-length job completes immediately
    en0 = en_cnt; bz0 = busy_cnt;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_base_addr = 32'h0000_4000; cfg_total_words = 0;
    @(posedge clk); #1;
    cfg_start = 1'b0;
    @(negedge clk);
    chk("zero_done_pulse", 64'(done), 64'd1);
    @(negedge clk);
    chk("zero_done_clear", 64'(done), 64'd0);
    repeat (3) @(negedge clk);
    chk("zero_no_en", 64'(en_cnt - en0), 64'd0);
    chk("zero_no_busy", 64'(busy_cnt - bz0), 64'd0);

    // Throttled stream, stalled beats, done coincident with last beat
    run_job(32'h0000_5000, 64, 50, 1, 1'b1);

    // Random jobs
    for (int j = 0; j < 4; j++) begin
      run_job($urandom & 32'hFFFF_FFC0, $urandom_range(50, 1),
              $urandom_range(90, 30), 2, 1'($urandom_range(1)));
    end

    // Reset in the middle of the first burst
    plan_job(32'h0000_6000, 32);
    pulse_start(32'h0000_6000, 32);
    fork
      source(100);
      begin
        cyc = 0;
        do begin
          @(negedge clk);
          cyc++;
        end while (!write_en_out && cyc < 1000);
        chk("reset_test_en_seen", 64'(write_en_out), 64'd1);
        @(posedge clk); #1; write_beat_in = 1'b1;
        @(posedge clk); #1; write_beat_in = 1'b1;
        @(posedge clk); #1; write_beat_in = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk_all_zero("midreset");
        sink_fin = 1'b1;
      end
    join
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    run_job(32'h0000_7000, 20, 70, 0, 1'b0);

    chk("fifo_no_overflow", 64'(max_occ <= 32), 64'd1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
